// File: rtl/bar_pattern_gen_multi.sv
// rtl/bar_pattern_gen_multi.sv - four-mode VGA test pattern generator (bars, ramp, checker, scrolling bars)
// Registered RGB output, one pixel clock behind the vga_hc/vga_vc counters.
module bar_pattern_gen_multi #(
   parameter int H_SIZE        = 10,
   parameter int V_SIZE        = 10,
   parameter int H_DISPLAY     = 640,
   parameter int V_DISPLAY     = 480,
   parameter int RGB_W         = 10,
   parameter int NUM_BARS      = 8,
   parameter int CHECK_LOG2    = 5,
   parameter int SCROLL_FRAMES = 30
) (
   input  logic              pixel_clk,
   input  logic              reset_n,
   input  logic [H_SIZE-1:0] vga_hc,
   input  logic [V_SIZE-1:0] vga_vc,
   input  logic [1:0]        mode,
   output logic [1:0]        mode_active,
   output logic [15:0]       frame_cnt,
   output logic [RGB_W-1:0]  vga_r,
   output logic [RGB_W-1:0]  vga_g,
   output logic [RGB_W-1:0]  vga_b
);

   localparam int BAR_W = H_DISPLAY / NUM_BARS;
   localparam int BP_W  = $clog2(BAR_W + 1);
   localparam int BI_W  = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
   localparam int SD_W  = $clog2(SCROLL_FRAMES + 1);
   localparam int F_INT = (2 ** RGB_W) - 1;
   localparam logic [RGB_W-1:0] F = '1;

   logic [BP_W-1:0]  bar_pix_q, bar_pix_d;
   logic [BI_W-1:0]  bar_idx_q, bar_idx_d;
   logic [BI_W-1:0]  scroll_idx_q, scroll_idx_d;
   logic [SD_W-1:0]  scroll_div_q, scroll_div_d;
   logic [1:0]       mode_active_q, mode_active_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic             seen_first_q, seen_first_d;
   logic [RGB_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

   logic            frame_start;
   logic [BI_W-1:0] cur_bar;
   logic [BI_W:0]   color_sum;
   logic [2:0]      cidx;
   logic [2:0]      bar_rgb;
   logic [RGB_W-1:0] ramp;

   always_comb begin
      bar_pix_d     = bar_pix_q;
      bar_idx_d     = bar_idx_q;
      scroll_idx_d  = scroll_idx_q;
      scroll_div_d  = scroll_div_q;
      mode_active_d = mode_active_q;
      frame_cnt_d   = frame_cnt_q;
      seen_first_d  = seen_first_q;
      r_d           = '0;
      g_d           = '0;
      b_d           = '0;
      bar_rgb       = 3'b000;
      ramp          = '0;

      frame_start = (vga_hc == '0) && (vga_vc == '0);

      // Tracker state at cycle hc holds the bar of pixel hc; hc==0 is forced to bar 0.
      if (vga_hc == '0) begin
         bar_pix_d = BP_W'(1);
         bar_idx_d = '0;
      end else if (bar_pix_q == BP_W'(BAR_W - 1)) begin
         bar_pix_d = '0;
         if (bar_idx_q != BI_W'(NUM_BARS - 1)) begin
            bar_idx_d = bar_idx_q + 1'b1;
         end
      end else begin
         bar_pix_d = bar_pix_q + 1'b1;
      end

      if (frame_start) begin
         mode_active_d = mode;
         seen_first_d  = 1'b1;
         if (seen_first_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
         if (scroll_div_q == SD_W'(SCROLL_FRAMES - 1)) begin
            scroll_div_d = '0;
            scroll_idx_d = (scroll_idx_q == BI_W'(NUM_BARS - 1)) ? '0 : scroll_idx_q + 1'b1;
         end else begin
            scroll_div_d = scroll_div_q + 1'b1;
         end
      end

      cur_bar   = (vga_hc == '0) ? '0 : bar_idx_q;
      color_sum = {1'b0, cur_bar} + ((mode_active_d == 2'd3) ? {1'b0, scroll_idx_d} : '0);
      if (color_sum >= (BI_W + 1)'(NUM_BARS)) begin
         color_sum = color_sum - (BI_W + 1)'(NUM_BARS);
      end
      cidx = 3'(color_sum);

      case (cidx)
         3'd0:    bar_rgb = 3'b111;
         3'd1:    bar_rgb = 3'b110;
         3'd2:    bar_rgb = 3'b011;
         3'd3:    bar_rgb = 3'b010;
         3'd4:    bar_rgb = 3'b101;
         3'd5:    bar_rgb = 3'b100;
         3'd6:    bar_rgb = 3'b001;
         default: bar_rgb = 3'b000;
      endcase

      ramp = (32'(vga_hc) > F_INT) ? F : RGB_W'(vga_hc);

      case (mode_active_d)
         2'd1: begin
            r_d = ramp;
            g_d = ramp;
            b_d = ramp;
         end
         2'd2: begin
            r_d = (vga_hc[CHECK_LOG2] ^ vga_vc[CHECK_LOG2]) ? F : '0;
            g_d = r_d;
            b_d = r_d;
         end
         default: begin
            r_d = bar_rgb[2] ? F : '0;
            g_d = bar_rgb[1] ? F : '0;
            b_d = bar_rgb[0] ? F : '0;
         end
      endcase

      if ((32'(vga_hc) >= H_DISPLAY) || (32'(vga_vc) >= V_DISPLAY)) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (!reset_n) begin
         bar_pix_q     <= '0;
         bar_idx_q     <= '0;
         scroll_idx_q  <= '0;
         scroll_div_q  <= '0;
         mode_active_q <= '0;
         frame_cnt_q   <= '0;
         seen_first_q  <= 1'b0;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
      end else begin
         bar_pix_q     <= bar_pix_d;
         bar_idx_q     <= bar_idx_d;
         scroll_idx_q  <= scroll_idx_d;
         scroll_div_q  <= scroll_div_d;
         mode_active_q <= mode_active_d;
         frame_cnt_q   <= frame_cnt_d;
         seen_first_q  <= seen_first_d;
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
      end
   end

   assign mode_active = mode_active_q;
   assign frame_cnt   = frame_cnt_q;
   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;

endmodule

// File: tb/tb_bar_pattern_gen_multi.sv
// tb/tb_bar_pattern_gen_multi.sv - randomized bench for bar_pattern_gen_multi against a pixel-rule model
// Two instances share stimulus: RGB_W=10 and RGB_W=8 (ramp saturation), both with SCROLL_FRAMES=2.
module tb_bar_pattern_gen_multi;

   localparam int HD = 640;
   localparam int VD = 480;
   localparam int NB = 8;
   localparam int BW = HD / NB;
   localparam int SF = 2;
   localparam int HT = 660;

   logic       pixel_clk = 1'b0;
   logic       reset_n   = 1'b0;
   logic [9:0] vga_hc    = '0;
   logic [9:0] vga_vc    = '0;
   logic [1:0] mode      = '0;

   logic [1:0]  ma_a, ma_b;
   logic [15:0] fc_a, fc_b;
   logic [9:0]  r_a, g_a, b_a;
   logic [7:0]  r_b, g_b, b_b;

   bar_pattern_gen_multi #(.RGB_W(10), .SCROLL_FRAMES(SF)) dut_a (
      .pixel_clk(pixel_clk), .reset_n(reset_n), .vga_hc(vga_hc), .vga_vc(vga_vc),
      .mode(mode), .mode_active(ma_a), .frame_cnt(fc_a),
      .vga_r(r_a), .vga_g(g_a), .vga_b(b_a));

   bar_pattern_gen_multi #(.RGB_W(8), .SCROLL_FRAMES(SF)) dut_b (
      .pixel_clk(pixel_clk), .reset_n(reset_n), .vga_hc(vga_hc), .vga_vc(vga_vc),
      .mode(mode), .mode_active(ma_b), .frame_cnt(fc_b),
      .vga_r(r_b), .vga_g(g_b), .vga_b(b_b));

   always #5 pixel_clk = ~pixel_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Frame starts since reset, the mode latched for this frame, and whether the bar tracker has seen hc=0.
   int k        = 0;
   int mode_cur = 0;
   bit line_ok  = 1'b0;
   int tbl [8]  = '{7, 6, 3, 2, 5, 4, 1, 0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (hc=%0d vc=%0d t=%0t)", tag, got, exp, vga_hc, vga_vc, $time);
      end
   endtask

   function automatic int pix(int hc, int vc, int md, int scr, int f, int ch);
      int c;
      if (hc >= HD || vc >= VD) return 0;
      case (md)
         1: return (hc > f) ? f : hc;
         2: return ((((hc >> 5) ^ (vc >> 5)) & 1) != 0) ? f : 0;
         3: c = ((hc / BW) + scr) % NB;
         default: c = hc / BW;
      endcase
      return ((tbl[c % 8] >> ch) & 1) != 0 ? f : 0;
   endfunction

   task automatic cycle(input bit rst, input int hc, input int vc, input int md);
      int  scr;
      bit  skip;
      reset_n = rst;
      vga_hc  = 10'(hc);
      vga_vc  = 10'(vc);
      mode    = 2'(md);
      @(posedge pixel_clk);
      #1;
      if (!rst) begin
         k = 0;
         mode_cur = 0;
         line_ok = 1'b0;
         check("rst_r", {22'b0, r_a}, 0);
         check("rst_g", {22'b0, g_a}, 0);
         check("rst_b", {22'b0, b_a}, 0);
         check("rst_mode", {30'b0, ma_a}, 0);
         check("rst_fcnt", {16'b0, fc_a}, 0);
         return;
      end
      if (hc == 0) line_ok = 1'b1;
      if (hc == 0 && vc == 0) begin
         k++;
         mode_cur = md;
      end
      scr  = (k / SF) % NB;
      skip = !line_ok && (mode_cur == 0 || mode_cur == 3);
      check("mode_active", {30'b0, ma_a}, 32'(mode_cur));
      check("frame_cnt", {16'b0, fc_a}, 32'((k == 0) ? 0 : (k - 1) % 65536));
      if (!skip) begin
         check("r10", {22'b0, r_a}, 32'(pix(hc, vc, mode_cur, scr, 1023, 2)));
         check("g10", {22'b0, g_a}, 32'(pix(hc, vc, mode_cur, scr, 1023, 1)));
         check("b10", {22'b0, b_a}, 32'(pix(hc, vc, mode_cur, scr, 1023, 0)));
         check("r8",  {24'b0, r_b}, 32'(pix(hc, vc, mode_cur, scr, 255, 2)));
         check("b8",  {24'b0, b_b}, 32'(pix(hc, vc, mode_cur, scr, 255, 0)));
         check("frame_cnt8", {16'b0, fc_b}, {16'b0, fc_a});
      end
   endtask

   // Lines per frame: vc=0 first, then a spread of active, checker-edge and blanked lines.
   task automatic run_frame(input int md0, input int md1, input int rst_line);
      int vcs [7];
      int md;
      vcs[0] = 0;
      vcs[1] = 32;
      vcs[2] = 31 + $urandom_range(0, 400);
      vcs[3] = 100;
      vcs[4] = $urandom_range(1, 524);
      vcs[5] = 480;
      vcs[6] = 479;
      for (int ln = 0; ln < 7; ln++) begin
         md = (ln >= 3) ? md1 : md0;
         for (int h = 0; h < HT; h++) begin
            cycle(!(ln == rst_line && h == 300), h, vcs[ln], md);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) cycle(1'b0, i, 0, 3);
      for (int h = 3; h < HT; h++) cycle(1'b1, h, 200, 0);
      run_frame(0, 2, -1);
      run_frame(1, 3, -1);
      run_frame(2, 0, -1);
      run_frame(3, 1, -1);
      run_frame(3, 2, -1);
      run_frame(3, 0, 2);
      for (int f = 0; f < 4; f++) begin
         run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bar_pattern_gen_multi.md
Name: bar_pattern_gen_multi

Overview:
- Parametrised successor to the single-colour bar pattern generator.
- Produces one of four VGA test patterns from the timing counters (vga_hc, vga_vc) supplied by the VGA timing block:
  - vertical colour bars
  - horizontal grey ramp
  - checkerboard
  - scrolling colour bars
- Sits between the VGA timing generator and the DAC/RGB output register.
- Output is registered, with one pixel clock of latency relative to the counters.

Parameters:
- H_SIZE, 10, width of vga_hc
- V_SIZE, 10, width of vga_vc
- H_DISPLAY, 640, active pixels per line
- V_DISPLAY, 480, active lines per frame
- RGB_W, 10, bits per colour channel
- NUM_BARS, 8, bars per line; must divide H_DISPLAY; BAR_W = H_DISPLAY/NUM_BARS
- CHECK_LOG2, 5, checker square side = 2^CHECK_LOG2 pixels
- SCROLL_FRAMES, 30, frames between one-bar scroll steps (>=1)

Ports:
- pixel_clk  input  1  pixel clock; all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- vga_hc  input  H_SIZE  horizontal counter; active region is 0..H_DISPLAY-1
- vga_vc  input  V_SIZE  vertical counter; active region is 0..V_DISPLAY-1
- mode  input  2  requested pattern: 0 bars, 1 ramp, 2 checker, 3 scrolling bars
- mode_active  output  2  pattern currently being drawn
- frame_cnt  output  16  completed-frame counter, wraps at 65535->0
- vga_r  output  RGB_W  red
- vga_g  output  RGB_W  green
- vga_b  output  RGB_W  blue

Behaviour:
- Reset:
  - One cycle with reset_n=0 on a pixel_clk edge clears all state.
  - Values after reset: vga_r/g/b=0, mode_active=0, frame_cnt=0, bar_idx=0, bar_pix=0, scroll_idx=0, scroll_div=0.
  - Reset mid-frame: outputs are 0 on the next cycle; drawing restarts cleanly at the next hc=0.
- Frame start: a cycle with vga_hc==0 and vga_vc==0.
  - mode_active <= mode. Mode changes mid-frame are ignored until the next frame start.
  - frame_cnt increments, except on the first frame start after reset, which is not counted.
  - scroll_div increments. When it reaches SCROLL_FRAMES-1 it wraps to 0, and scroll_idx <= (scroll_idx+1) mod NUM_BARS.
- Bar tracking (no divider):
  - bar_pix counts pixels within the current bar; bar_idx is the bar number.
  - When vga_hc==0: bar_pix<=1, bar_idx<=0. The pixel at hc=0 uses bar 0.
  - Otherwise, when bar_pix==BAR_W-1: bar_pix<=0 and bar_idx++. Else bar_pix++.
  - bar_idx saturates at NUM_BARS-1.
- Colour bar table, indexed by colour index c mod 8. F = all ones (2^RGB_W-1).
  - 0 white (F,F,F)
  - 1 yellow (F,F,0)
  - 2 cyan (0,F,F)
  - 3 green (0,F,0)
  - 4 magenta (F,0,F)
  - 5 red (F,0,0)
  - 6 blue (0,0,F)
  - 7 black (0,0,0)
- Pattern per mode:
  - Mode 0: c = bar_idx.
  - Mode 1: r=g=b = min(vga_hc, F).
  - Mode 2: white if vga_hc[CHECK_LOG2] XOR vga_vc[CHECK_LOG2] is 1, else black.
  - Mode 3: c = (bar_idx + scroll_idx) mod NUM_BARS.
- Blanking: if vga_hc>=H_DISPLAY or vga_vc>=V_DISPLAY, the outputs are 0.
- Latency: counters at cycle N produce the outputs registered at edge N+1.
  - The bar tracker must be aligned so that bar boundaries fall exactly at hc = k*BAR_W.
- Simultaneous events: reset_n=0 overrides frame start. A frame start coincident with a bar boundary uses the hc=0 rule.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with counters running -> vga_r/g/b=0, mode_active=0 and frame_cnt=0 throughout and on the cycle after release.
- Mode 0, H_DISPLAY=640, NUM_BARS=8, RGB_W=10:
  - hc=0..79 -> (3FF,3FF,3FF)
  - hc=80 -> (3FF,3FF,0)
  - hc=559 -> (0,0,3FF)
  - hc=560..639 -> (0,0,0)
  - hc=640 -> 0 (blanked)
  - Every output appears one cycle after its hc.
- Mode 1:
  - hc=5 -> r=g=b=5
  - hc=639 -> 27F
  - vc=480, any hc -> 0
  - With RGB_W=8, hc=300 -> FF (saturated)
- Mode 2, CHECK_LOG2=5:
  - (hc=0,vc=0) -> black
  - (hc=32,vc=0) -> white
  - (hc=32,vc=32) -> black
- Mode 3, SCROLL_FRAMES=2: run 4 frames -> scroll_idx is 2. In the 5th frame, hc=0 shows cyan (0,3FF,3FF) and hc=560 shows yellow (3FF,3FF,0).
- Mode switch mid-frame: change mode 0->2 at vc=100 -> mode_active stays 0 until the next frame start, then becomes 2. frame_cnt increments by exactly 1 per frame.
